// File: rtl/kappa3_pkg.sv
// kappa3 run controller shared definitions.
// Phase one-hot codes, mode codes and phase helpers.
package kappa3_pkg;

    localparam logic [3:0] PH_F = 4'b0001;
    localparam logic [3:0] PH_D = 4'b0010;
    localparam logic [3:0] PH_E = 4'b0100;
    localparam logic [3:0] PH_W = 4'b1000;

    localparam logic [2:0] MD_IDLE     = 3'd0;
    localparam logic [2:0] MD_RUN      = 3'd1;
    localparam logic [2:0] MD_STEP_PH  = 3'd2;
    localparam logic [2:0] MD_STEP_IN  = 3'd3;
    localparam logic [2:0] MD_STOP_REQ = 3'd4;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    function automatic logic [3:0] next_phase(input logic [3:0] v);
        logic [3:0] n;
        n = PH_F;
        case (v)
            PH_F:    n = PH_D;
            PH_D:    n = PH_E;
            PH_E:    n = PH_W;
            PH_W:    n = PH_F;
            default: n = PH_F;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/kappa3_run_ctrl_rise_det.sv
// Single-bit rising-edge detector for debugger buttons.
// prev resets to 1 so a button held through reset gives no edge.
module rise_det (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    output logic o_edge
);

    logic r_prev;

    // remember last sample of the button level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_d;
        end
    end

    assign o_edge = i_d & ~r_prev;

endmodule

// File: rtl/kappa3_run_ctrl.sv
// kappa3 debugger run/step controller.
// Sequences F/D/E/W phases under run, step and halt control.
module kappa3_run_ctrl
    import kappa3_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       step_phase,
    input  logic       step_inst,
    input  logic       halt,
    output logic [3:0] cstate,
    output logic       running,
    output logic       phase_en
);

    logic [2:0] r_mode;
    logic [2:0] w_mode_nxt;
    logic [3:0] r_cstate;
    logic       w_run_e;
    logic       w_sp_e;
    logic       w_si_e;
    logic       w_active;
    logic       w_at_w;

    rise_det u_run_det (
        .clock  (clock),
        .reset  (reset),
        .i_d    (run),
        .o_edge (w_run_e)
    );

    rise_det u_sp_det (
        .clock  (clock),
        .reset  (reset),
        .i_d    (step_phase),
        .o_edge (w_sp_e)
    );

    rise_det u_si_det (
        .clock  (clock),
        .reset  (reset),
        .i_d    (step_inst),
        .o_edge (w_si_e)
    );

    // core is enabled in every mode except IDLE
    always_comb begin
        w_active = 1'b0;
        case (r_mode)
            MD_RUN,
            MD_STEP_PH,
            MD_STEP_IN,
            MD_STOP_REQ: w_active = 1'b1;
            default:     w_active = 1'b0;
        endcase
    end

    assign w_at_w   = w_active && (r_cstate == PH_W);
    assign phase_en = w_active;
    assign running  = w_active;
    assign cstate   = r_cstate;

    // mode transitions; instruction boundary is the end of an enabled W
    always_comb begin
        w_mode_nxt = r_mode;
        case (r_mode)
            MD_IDLE: begin
                if (w_run_e) begin
                    w_mode_nxt = MD_RUN;
                end else if (w_si_e) begin
                    w_mode_nxt = MD_STEP_IN;
                end else if (w_sp_e) begin
                    w_mode_nxt = MD_STEP_PH;
                end
            end
            MD_RUN: begin
                if (w_at_w && (halt || w_run_e)) begin
                    w_mode_nxt = MD_IDLE;
                end else if (w_run_e) begin
                    w_mode_nxt = MD_STOP_REQ;
                end
            end
            MD_STEP_PH: begin
                w_mode_nxt = MD_IDLE;
            end
            MD_STEP_IN,
            MD_STOP_REQ: begin
                if (w_at_w) begin
                    w_mode_nxt = MD_IDLE;
                end
            end
            default: begin
                w_mode_nxt = MD_IDLE;
            end
        endcase
    end

    // mode register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mode <= MD_IDLE;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    // phase rotates when enabled; corrupt codes fall back to F
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cstate <= PH_F;
        end else if (!is_onehot(r_cstate)) begin
            r_cstate <= PH_F;
        end else if (w_active) begin
            r_cstate <= next_phase(r_cstate);
        end
    end

endmodule

// File: tb/tb_kappa3_run_ctrl.sv
// Self-checking bench for kappa3_run_ctrl.
// Directed scenarios then random button/halt traffic vs a phase-budget model.
module tb_kappa3_run_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       run;
    logic       step_phase;
    logic       step_inst;
    logic       halt;
    logic [3:0] cstate;
    logic       running;
    logic       phase_en;

    int checks   = 0;
    int failures = 0;
    int pe_cnt   = 0;

    // model: current phase index and remaining enabled cycles
    // (m_rem: 0 = idle, -1 = free running, >0 = phases left)
    int   m_ph;
    int   m_rem;
    logic m_pr;
    logic m_psp;
    logic m_psi;

    kappa3_run_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .step_phase (step_phase),
        .step_inst  (step_inst),
        .halt       (halt),
        .cstate     (cstate),
        .running    (running),
        .phase_en   (phase_en)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_ph  = 0;
        m_rem = 0;
        m_pr  = 1'b1;
        m_psp = 1'b1;
        m_psi = 1'b1;
    endfunction

    function automatic void m_step();
        logic re;
        logic spe;
        logic sie;
        int   p;
        re    = run & ~m_pr;
        spe   = step_phase & ~m_psp;
        sie   = step_inst & ~m_psi;
        m_pr  = run;
        m_psp = step_phase;
        m_psi = step_inst;
        if (m_rem == 0) begin
            if (re)       m_rem = -1;
            else if (sie) m_rem = 4 - m_ph;
            else if (spe) m_rem = 1;
        end else begin
            p    = m_ph;
            m_ph = (m_ph + 1) % 4;
            if (p == 3 && halt) begin
                m_rem = 0;
            end else if (m_rem == -1) begin
                if (re) m_rem = 3 - p;
            end else begin
                m_rem = m_rem - 1;
            end
        end
    endfunction

    task automatic cyc(input logic r, input logic sp,
                       input logic si, input logic h);
        run        = r;
        step_phase = sp;
        step_inst  = si;
        halt       = h;
        @(negedge clock);
        chk("phase_en", phase_en, m_rem != 0);
        chk("running", running, m_rem != 0);
        chk("cstate", cstate, 4'b0001 << m_ph);
        if (phase_en) pe_cnt++;
        @(posedge clock);
        m_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_reset();
        chk("rst_cstate", cstate, 4'b0001);
        chk("rst_running", running, 1'b0);
        chk("rst_phase_en", phase_en, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        m_step();
        #1;
    endtask

    initial begin
        run        = 1'b0;
        step_phase = 1'b0;
        step_inst  = 1'b0;
        halt       = 1'b0;
        do_reset();

        // single phase step
        pe_cnt = 0;
        cyc(0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        chk("ph_step_pe", pe_cnt, 1);
        chk("ph_step_cs", cstate, 4'b0010);
        chk("ph_step_run", running, 1'b0);

        // instruction step from F
        do_reset();
        pe_cnt = 0;
        cyc(0, 0, 1, 0);
        repeat (5) cyc(0, 0, 0, 0);
        chk("in_step_pe", pe_cnt, 4);
        chk("in_step_cs", cstate, 4'b0001);
        chk("in_step_run", running, 1'b0);

        // instruction step from D stops at the boundary
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        pe_cnt = 0;
        cyc(0, 0, 1, 0);
        repeat (5) cyc(0, 0, 0, 0);
        chk("in_step_d_pe", pe_cnt, 3);
        chk("in_step_d_cs", cstate, 4'b0001);

        // run then stop at D
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        pe_cnt = 0;
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (4) cyc(1, 0, 0, 0);
        chk("stop_pe", pe_cnt, 3);
        chk("stop_cs", cstate, 4'b0001);
        chk("stop_run", running, 1'b0);
        cyc(0, 0, 0, 0);

        // halt held from E of second instruction
        do_reset();
        pe_cnt = 0;
        cyc(1, 0, 0, 0);
        for (int j = 0; j < 12; j++) cyc(0, 0, 0, j >= 6);
        chk("halt_pe", pe_cnt, 8);
        chk("halt_cs", cstate, 4'b0001);
        chk("halt_run", running, 1'b0);
        cyc(0, 0, 0, 0);

        // simultaneous edges, then ignored step pulses
        do_reset();
        cyc(1, 1, 1, 0);
        for (int j = 0; j < 6; j++) cyc(1, j[0], j[1], 0);
        chk("simul_run", running, 1'b1);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (6) cyc(1, 0, 0, 0);
        chk("simul_stop", running, 1'b0);

        // run held through reset release
        run = 1'b1;
        do_reset();
        pe_cnt = 0;
        repeat (4) cyc(1, 0, 0, 0);
        chk("held_pe", pe_cnt, 0);

        // reset mid-instruction at E
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int j = 0; j < 8; j++) begin
            if (!(m_ph == 2 && m_rem != 0)) cyc(1, 0, 0, 0);
        end
        chk("pre_abort_cs", cstate, 4'b0100);
        reset = 1'b1;
        #1;
        chk("abort_cs", cstate, 4'b0001);
        chk("abort_run", running, 1'b0);
        run = 1'b0;
        do_reset();

        // random traffic
        for (int i = 0; i < 800; i++) begin
            logic r;
            logic sp;
            logic si;
            logic h;
            r  = ($urandom_range(0, 5) == 0) ? ~run : run;
            sp = ($urandom_range(0, 3) == 0) ? ~step_phase : step_phase;
            si = ($urandom_range(0, 4) == 0) ? ~step_inst : step_inst;
            h  = ($urandom_range(0, 2) == 0);
            cyc(r, sp, si, h);
            if (i == 400) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kappa3_run_ctrl.md
KAPPA3_RUN_CTRL -- requirements
Module: kappa3_run_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port: clock  in  1  CPU clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: run  in  1  debugger run/stop button, level; acts on its rising edge.
REQ-005 Port: step_phase  in  1  debugger single-phase step button, level; acts on its rising edge.
REQ-006 Port: step_inst  in  1  debugger single-instruction step button, level; acts on its rising edge.
REQ-007 Port: halt  in  1  core halt request (e.g. HALT instruction); sampled only as in REQ-019.
REQ-008 Port: cstate  out  4  one-hot phase: 0001 F (fetch), 0010 D (decode), 0100 E (execute), 1000 W (writeback).
REQ-009 Port: running  out  1  high while mode is not IDLE.
REQ-010 Port: phase_en  out  1  core performs the phase given by cstate in this cycle.

Function
REQ-011 SHALL detect rising edges of run, step_phase and step_inst: previous-sample register per input; edge = in & ~prev.
REQ-012 SHALL implement modes IDLE, RUN, STEP_PH, STEP_IN and STOP_REQ.
REQ-013 phase_en SHALL be combinational: 1 iff mode is RUN, STEP_PH, STEP_IN or STOP_REQ; running SHALL equal phase_en.
REQ-014 cstate SHALL rotate F->D->E->W->F on each clock edge where phase_en=1, and hold otherwise.
REQ-015 IDLE SHALL transition on a command edge: run -> RUN, else step_inst -> STEP_IN, else step_phase -> STEP_PH. Priority on simultaneous edges is run > step_inst > step_phase.
REQ-016 Latency SHALL be one cycle: an edge sampled at clock edge k gives phase_en=1 in the cycle after k.
REQ-017 STEP_PH SHALL return to IDLE after exactly one phase_en cycle, giving one cstate rotation.
REQ-018 STEP_IN SHALL return to IDLE at the edge where cstate=W and phase_en=1, leaving cstate=F. A step_inst issued at a non-F phase runs only to the next instruction boundary.
REQ-019 In RUN, STEP_IN or STOP_REQ, halt=1 at a W phase_en cycle SHALL force IDLE at that edge. halt SHALL be ignored in all other cycles.
REQ-020 A run edge in RUN SHALL enter STOP_REQ. STOP_REQ SHALL continue to the end of W, then go to IDLE with cstate=F.
REQ-021 A run edge in STEP_IN SHALL have no effect: stop occurs at the same boundary.
REQ-022 step_phase and step_inst edges outside IDLE SHALL be discarded, not queued.
REQ-023 A run edge in STOP_REQ SHALL be ignored; the stop still completes.
REQ-024 cstate SHALL never hold a non-one-hot value. Any illegal value SHALL recover to F on the next clock edge.

Reset
REQ-025 On reset: mode=IDLE, cstate=0001, running=0, phase_en=0, all previous-sample registers=1.
REQ-026 Because previous-sample registers reset to 1, a button held through reset release SHALL produce no edge.
REQ-027 Reset asserted mid-instruction SHALL abort immediately, with no completion of the current phase.

Structure
REQ-028 Shared package kappa3_pkg SHALL hold the cstate phase constants (PH_F/D/E/W) and the mode encoding constants.
REQ-029 One sub-module, rise_det (1-bit edge detector, prev reset to 1), SHALL be instantiated three times.
REQ-030 Target size is 120-250 lines of RTL. There SHALL be no other sub-modules.

Verification
REQ-031 Reset, then one step_phase pulse -> phase_en high for exactly 1 cycle; cstate 0001->0010; running returns to 0.
REQ-032 From F, step_inst pulse -> phase_en high for 4 consecutive cycles; cstate 0001,0010,0100,1000 then 0001; running=0 after.
REQ-033 run pulse, then a second run pulse at cstate=0010 -> W completes, idle at cstate=0001; 3 further phase_en cycles after the stop edge.
REQ-034 RUN with halt=1 held from the E phase of the 2nd instruction -> stop at the end of that W; total phase_en cycles = 8.
REQ-035 run, step_inst and step_phase rising in the same cycle from IDLE -> RUN mode; step_phase pulses while running leave the cstate sequence unaltered.
REQ-036 run held high across reset release -> no phase_en. Reset asserted at cstate=0100 in RUN -> cstate=0001 and running=0 immediately.
